// File: rtl/qmac_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | qmac_pipe: 3-stage signed Q-format multiply-accumulate, round + saturate |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qmac_pipe #(
  parameter int N = 32,
  parameter int Q = 15,
  parameter int G = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_first,
  input  logic         i_last,
  input  logic         i_round,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_ovr
);

  localparam int AW = 2*N + G;

  logic                 w_en;
  logic signed [2*N-1:0] w_a_ext;
  logic signed [2*N-1:0] w_b_ext;
  logic signed [2*N-1:0] prod_d;
  logic signed [AW-1:0]  acc_d;
  logic signed [AW-1:0]  w_half;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_r;
  logic [N-1:0]          res_d;
  logic                  ovr_d;

  logic                  v1_q;
  logic signed [2*N-1:0] p1_q;
  logic                  first1_q;
  logic                  last1_q;
  logic                  round1_q;
  logic                  v2_q;
  logic                  round2_q;
  logic signed [AW-1:0]  acc_q;
  logic                  valid_q;
  logic [N-1:0]          res_q;
  logic                  ovr_q;

  // The whole pipe advances together; a held output freezes every stage.
  assign w_en     = !valid_q || i_ready;
  assign o_ready  = w_en;
  assign o_valid  = valid_q;
  assign o_result = res_q;
  assign o_ovr    = ovr_q;

  assign w_a_ext = {{N{i_a[N-1]}}, i_a};
  assign w_b_ext = {{N{i_b[N-1]}}, i_b};

  always_comb begin
    prod_d = w_a_ext * w_b_ext;
    acc_d  = (first1_q ? '0 : acc_q) + {{G{p1_q[2*N-1]}}, p1_q};
    w_half = '0;
    w_half[Q-1] = 1'b1;
    w_sum  = acc_q + (round2_q ? w_half : '0);
    w_r    = w_sum >>> Q;
    res_d  = w_r[N-1:0];
    ovr_d  = 1'b0;
    // Fits in N bits only when every bit above the result sign matches it.
    if (!((&w_r[AW-1:N-1]) || (~|w_r[AW-1:N-1]))) begin
      ovr_d = 1'b1;
      res_d = w_r[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      p1_q     <= '0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      round1_q <= 1'b0;
      v2_q     <= 1'b0;
      round2_q <= 1'b0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      res_q    <= '0;
      ovr_q    <= 1'b0;
    end else if (w_en) begin
      v1_q <= i_valid;
      if (i_valid) begin
        p1_q     <= prod_d;
        first1_q <= i_first;
        last1_q  <= i_last;
        round1_q <= i_round;
      end
      v2_q <= v1_q && last1_q;
      if (v1_q) begin
        acc_q    <= acc_d;
        round2_q <= round1_q;
      end
      valid_q <= v2_q;
      if (v2_q) begin
        res_q <= res_d;
        ovr_q <= ovr_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qmac_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboarded bench for qmac_pipe: directed spec cases plus randomized
// sequences under random backpressure, checked against an arithmetic model.
module tb_qmac_pipe;

  localparam int N = 32;
  localparam int Q = 15;
  localparam int G = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [N-1:0]  i_a;
  logic [N-1:0]  i_b;
  logic          i_first;
  logic          i_last;
  logic          i_round;
  logic          o_valid;
  logic          i_ready;
  logic [N-1:0]  o_result;
  logic          o_ovr;

  always #5 clk = ~clk;

  qmac_pipe #(.N(N), .Q(Q), .G(G)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b),
    .i_first(i_first), .i_last(i_last), .i_round(i_round),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_ovr(o_ovr)
  );

  int errors = 0;
  int checks = 0;
  logic [32:0] sbq[$];            // {result, ovr}
  logic signed [71:0] macc;       // reference running sum, full precision
  logic        dir_en;
  logic [32:0] dir_val;
  logic        stim_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Real-valued rule: sum * 2^-2Q, optional +half LSB, floor to Q bits, clamp.
  function automatic logic [32:0] model_out(input logic signed [71:0] acc, input logic rnd);
    logic signed [71:0] r;
    r = (acc + (rnd ? 72'sd16384 : 72'sd0)) >>> Q;
    if (r > 72'sd2147483647)       return {32'h7FFFFFFF, 1'b1};
    else if (r < -72'sd2147483648) return {32'h80000000, 1'b1};
    else                           return {r[31:0], 1'b0};
  endfunction

  function automatic logic [31:0] rnd_op();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)      return 32'($urandom_range(0, 1 << 19)) - 32'(1 << 18);
    else if (k < 9) return 32'($urandom_range(0, 1 << 25)) - 32'(1 << 24);
    else            return $urandom;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                           input logic f, input logic l, input logic r);
    int tries;
    logic ok;
    logic signed [71:0] xa, xb;
    tries = 0;
    i_valid = 1'b1; i_a = a; i_b = b; i_first = f; i_last = l; i_round = r;
    forever begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk);
      if (ok) break;
      #1;
      tries++;
      if (tries > 2000) begin
        checks++; errors++;
        $display("FAIL send_timeout: got no accept expected accept");
        i_valid = 1'b0;
        return;
      end
    end
    xa = {{40{a[31]}}, a};
    xb = {{40{b[31]}}, b};
    if (f) macc = '0;
    macc = macc + xa * xb;
    if (l) begin
      if (dir_en) begin
        sbq.push_back(dir_val);
        dir_en = 1'b0;
      end else begin
        sbq.push_back(model_out(macc, r));
      end
    end
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic r,
                       input logic [31:0] er, input logic eo);
    dir_en = 1'b1;
    dir_val = {er, eo};
    send_beat(a, b, 1'b1, 1'b1, r);
  endtask

  task automatic send_rand_seq(input int len);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_beat(rnd_op(), rnd_op(), (i == 0) && ($urandom_range(0, 7) != 0),
                i == len - 1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || o_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: pops expected results on every output handshake, checks holds.
  initial begin
    logic        stall;
    logic [32:0] hold;
    logic [32:0] e;
    stall = 1'b0;
    hold  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("stall_hold", {o_valid, o_result, o_ovr}, {1'b1, hold});
        if (o_valid && !i_ready) begin
          stall = 1'b1;
          hold  = {o_result, o_ovr};
        end else begin
          stall = 1'b0;
          if (o_valid) begin
            if (sbq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_result: got %h expected none", o_result);
            end else begin
              e = sbq.pop_front();
              chk("result", {o_result, o_ovr}, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0;
    i_first = 1'b0; i_last = 1'b0; i_round = 1'b0; i_ready = 1'b1;
    dir_en = 1'b0; dir_val = '0; macc = '0; stim_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_result", o_result, 0);
    chk("rst_ovr", o_ovr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single term with latency: valid appears after the third edge.
    send1(32'h0000C000, 32'hFFFF0000, 1'b0, 32'hFFFE8000, 1'b0);
    @(negedge clk); chk("lat_e0", o_valid, 0);
    @(negedge clk); chk("lat_e1", o_valid, 0);
    @(negedge clk); chk("lat_e2", o_valid, 1);
    @(posedge clk); #1;
    drain();

    send1(32'h00960000, 32'h00960000, 1'b0, 32'h7FFFFFFF, 1'b1);
    send1(32'h00960000, 32'hFF6A0000, 1'b0, 32'h80000000, 1'b1);
    send1(32'h00000001, 32'h00004000, 1'b0, 32'h00000000, 1'b0);
    send1(32'h00000001, 32'h00004000, 1'b1, 32'h00000001, 1'b0);
    send1(32'hFFFFFFFF, 32'h00004000, 1'b0, 32'hFFFFFFFF, 1'b0);
    send1(32'hFFFFFFFF, 32'h00004000, 1'b1, 32'h00000000, 1'b0);
    drain();

    // Consecutive-cycle accumulate, then an immediate single-term sequence.
    send_beat(32'h00008000, 32'h00010000, 1'b1, 1'b0, 1'b0);
    send_beat(32'h00004000, 32'h00020000, 1'b0, 1'b0, 1'b0);
    dir_en = 1'b1; dir_val = {32'h00018000, 1'b0};
    send_beat(32'h00002000, 32'hFFFE0000, 1'b0, 1'b1, 1'b0);
    send1(32'h00008000, 32'h00008000, 1'b0, 32'h00008000, 1'b0);
    drain();

    // Backpressure: 4-cycle stall while beats keep being offered.
    fork
      begin
        send_rand_seq(2);
        send_rand_seq(1);
        send_rand_seq(3);
        send_rand_seq(2);
      end
      begin
        int n;
        n = 0;
        while (!o_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk("bp_saw_valid", o_valid, 1);
        i_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_ready_low", o_ready, 0);
          @(posedge clk); #1;
        end
        i_ready = 1'b1;
      end
    join
    drain();

    // Randomized sequences under random downstream readiness.
    fork
      begin
        for (int s = 0; s < 60; s++) send_rand_seq($urandom_range(1, 5));
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-sequence discards the partial sum.
    send_beat(32'h00008000, 32'h00008000, 1'b1, 1'b0, 1'b0);
    send_beat(32'h00010000, 32'h00008000, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ready", o_ready, 1);
    macc = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dir_en = 1'b1; dir_val = {32'h00008000, 1'b0};
    send_beat(32'h00008000, 32'h00008000, 1'b0, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
